commit_trace_buffer: RTL and testbench
======================================

// Module: commit_trace_buffer
// PURPOSE
//  Captures retire events (WB-stage register writes, incl. loads) and MA-stage store events
//  into a FIFO of trace records, drained over a valid/ready stream to the trace printer/host.
//  Sits between WriteBackStage/MemoryAccessStage and the debug trace sink; decouples sink stalls.
// PARAMETERS
//  DEPTH   8   FIFO entries; power of two, >= 4
//  PC_W    32  PC field width
//  DROP_W  16  width of saturating dropped-record counter
// PORTS
//  clk         in   1      clock
//  rst         in   1      synchronous, active-high reset
//  wbValid     in   1      WB register write retiring (rdCtrl.wEnable)
//  wbPc        in   PC_W   PC of WB instruction
//  wbRd        in   5      destination register
//  wbData      in   32     written value
//  wbIsLoad    in   1      WB instruction is a load
//  wbMemAddr   in   32     load address (valid when wbIsLoad)
//  stValid     in   1      MA store write enable this cycle
//  stPc        in   PC_W   PC of store
//  stAddr      in   32     store address
//  stData      in   32     store data
//  hcIn        in   32     hardware cycle counter
//  trValid     out  1      head record available
//  trReady     in   1      sink accepts head record
//  trKind      out  2      0=REG 1=LOAD 2=STORE (3 unused)
//  trPc        out  PC_W   record PC
//  trRd        out  5      rd (0 for STORE)
//  trData      out  32     written value / store data
//  trAddr      out  32     memory address (0 for REG)
//  trHc        out  32     timestamp (see CONFIGURATION)
//  overflow    out  1      sticky: at least one record dropped since reset
//  dropCount   out  DROP_W dropped records, saturating at all-ones
// BEHAVIOUR
//  - Reset: FIFO empty, pointers 0, trValid=0, overflow=0, dropCount=0; record outputs 0 when empty.
//    Reset mid-operation discards all queued records; inputs ignored while rst=1.
//  - Record kind: wbValid&wbIsLoad -> LOAD (trAddr=wbMemAddr); wbValid&!wbIsLoad -> REG; stValid -> STORE.
//  - Up to 2 pushes/cycle. Same-cycle wbValid & stValid: WB record enqueued first (older instr),
//    STORE second. Records stamped with hcIn of the capture cycle.
//  - First-word-fall-through: trValid = (count != 0); head fields stable while trValid & !trReady.
//    Pop on trValid & trReady. Latency: event at cycle N visible at head at N+1 if FIFO empty.
//  - free = DEPTH - count + pop; pop in the same cycle frees a slot for this cycle's push.
//  - free >= needed: all pushed. free==1 with 2 events: WB pushed, STORE dropped.
//    free==0: all events this cycle dropped. Each dropped record: dropCount += 1 (saturating;
//    +2 if both dropped), overflow set and held until reset.
//  - Pointers log2(DEPTH) bits, wrap naturally; count log2(DEPTH)+1 bits, 0..DEPTH.
//  - count' = count + pushed - pop; never exceeds DEPTH, never underflows.
// CONFIGURATION
//  COMMIT_TRACE_HC_EN defined: hcIn stored per entry, trHc = captured hcIn.
//  Not defined: no timestamp storage, hcIn unused, trHc tied to 0.
// TESTING
//  1 Reset, single wbValid pc=0x10 rd=5 data=0xDEADBEEF, trReady=1 -> next cycle trValid=1,
//    kind=REG, rd=5, data=0xDEADBEEF; following cycle trValid=0.
//  2 Same-cycle wb load (pc=0x20, addr=0x100) + store (pc=0x24, addr=0x200, data=0x55) ->
//    records LOAD then STORE in order, trAddr 0x100 then 0x200.
//  3 trReady=0, push 10 REG events with DEPTH=8 -> 8 queued, dropCount=2, overflow=1;
//    then drain: first 8 events in order, overflow stays 1.
//  4 FIFO full, trReady=1, one wbValid same cycle -> accepted (pop frees slot), dropCount unchanged.
//  5 FIFO holds 7, trReady=0, wb+store same cycle -> WB queued, STORE dropped, dropCount+=1.
//  6 Reset asserted with 5 queued -> trValid=0, dropCount=0, overflow=0 next cycle; with
//    COMMIT_TRACE_HC_EN, trHc equals hcIn at capture, else 0.

Source files
------------

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: captures WB-stage register retirements (incl. loads) and MA-stage
// stores into a first-word-fall-through FIFO of trace records. The FIFO drains to the trace
// sink over a valid/ready stream. Records that do not fit are dropped and counted.
//
// Optional feature: define COMMIT_TRACE_HC_EN to store hcIn with every record and present it
// on trHc. Without it no timestamp storage is built and trHc reads 0.
module commit_trace_buffer #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned DROP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    // WB-stage retirement
    input  logic              wbValid,
    input  logic [PC_W-1:0]   wbPc,
    input  logic [4:0]        wbRd,
    input  logic [31:0]       wbData,
    input  logic              wbIsLoad,
    input  logic [31:0]       wbMemAddr,
    // MA-stage store
    input  logic              stValid,
    input  logic [PC_W-1:0]   stPc,
    input  logic [31:0]       stAddr,
    input  logic [31:0]       stData,
    // Timestamp source
    input  logic [31:0]       hcIn,
    // Trace stream
    output logic              trValid,
    input  logic              trReady,
    output logic [1:0]        trKind,
    output logic [PC_W-1:0]   trPc,
    output logic [4:0]        trRd,
    output logic [31:0]       trData,
    output logic [31:0]       trAddr,
    output logic [31:0]       trHc,
    // Drop reporting
    output logic              overflow,
    output logic [DROP_W-1:0] dropCount
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = DROP_W + 1;

    localparam logic [1:0] KIND_REG   = 2'd0;
    localparam logic [1:0] KIND_LOAD  = 2'd1;
    localparam logic [1:0] KIND_STORE = 2'd2;

    typedef struct packed {
        logic [1:0]      kind;
        logic [PC_W-1:0] pc;
        logic [4:0]      rd;
        logic [31:0]     data;
        logic [31:0]     addr;
    } rec_t;

    // Storage and state
    rec_t              rec_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    // Per-cycle control
    logic              wb_evt, st_evt;
    logic              pop;
    logic [CNT_W-1:0]  free;
    logic              push_wb, push_st;
    logic [1:0]        n_push, n_drop;
    logic [SUM_W-1:0]  drop_sum;
    logic              we0, we1;
    logic [PTR_W-1:0]  slot1;
    rec_t              wb_rec, st_rec, rec0;
    rec_t              head;

    // Inputs are ignored entirely while reset is asserted
    assign wb_evt = wbValid & ~rst;
    assign st_evt = stValid & ~rst;

    // Build the candidate records for this cycle
    always_comb begin
        wb_rec      = '0;
        wb_rec.kind = wbIsLoad ? KIND_LOAD : KIND_REG;
        wb_rec.pc   = wbPc;
        wb_rec.rd   = wbRd;
        wb_rec.data = wbData;
        wb_rec.addr = wbIsLoad ? wbMemAddr : 32'd0;

        st_rec      = '0;
        st_rec.kind = KIND_STORE;
        st_rec.pc   = stPc;
        st_rec.rd   = 5'd0;
        st_rec.data = stData;
        st_rec.addr = stAddr;
    end

    // Push/drop arbitration: a same-cycle pop frees a slot; WB (older) wins the last slot
    always_comb begin
        pop      = trValid & trReady & ~rst;
        free     = CNT_W'(DEPTH) - count_q + CNT_W'(pop);
        push_wb  = wb_evt && (free != '0);
        push_st  = st_evt && (free > CNT_W'(push_wb));
        n_push   = {1'b0, push_wb} + {1'b0, push_st};
        n_drop   = {1'b0, wb_evt & ~push_wb} + {1'b0, st_evt & ~push_st};

        // The first write slot takes WB if it is pushed, otherwise the store
        we0      = push_wb | push_st;
        we1      = push_wb & push_st;
        rec0     = push_wb ? wb_rec : st_rec;
        slot1    = wr_ptr_q + PTR_W'(1);
    end

    // Next-state for pointers, occupancy and drop bookkeeping
    always_comb begin
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d   = wr_ptr_q + PTR_W'(n_push);
        count_d    = count_q + CNT_W'(n_push) - CNT_W'(pop);
        drop_sum   = {1'b0, drop_q} + SUM_W'(n_drop);
        // Saturate at all-ones when the add carries out
        drop_d     = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
        overflow_d = overflow_q | (n_drop != 2'd0);
    end

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Record storage; contents are don't-care while the slot is not occupied
    always_ff @(posedge clk) begin
        if (we0) begin
            rec_mem[wr_ptr_q] <= rec0;
        end
        if (we1) begin
            rec_mem[slot1] <= st_rec;
        end
    end

`ifdef COMMIT_TRACE_HC_EN
    logic [31:0] hc_mem [DEPTH];

    // Timestamp storage written alongside the records with the capture-cycle hcIn
    always_ff @(posedge clk) begin
        if (we0) begin
            hc_mem[wr_ptr_q] <= hcIn;
        end
        if (we1) begin
            hc_mem[slot1] <= hcIn;
        end
    end

    assign trHc = trValid ? hc_mem[rd_ptr_q] : 32'd0;
`else
    logic unused_hc;

    assign unused_hc = ^hcIn;
    assign trHc      = 32'd0;
`endif

    // Head presentation: fields forced to zero when empty
    always_comb begin
        head    = rec_mem[rd_ptr_q];
        trValid = (count_q != '0);
        trKind  = trValid ? head.kind : 2'd0;
        trPc    = trValid ? head.pc   : '0;
        trRd    = trValid ? head.rd   : 5'd0;
        trData  = trValid ? head.data : 32'd0;
        trAddr  = trValid ? head.addr : 32'd0;
    end

    assign overflow  = overflow_q;
    assign dropCount = drop_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: directed scenarios followed by randomized
// traffic, all compared against a queue-based reference model of the trace FIFO.
module tb_commit_trace_buffer;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned PC_W   = 32;
    localparam int unsigned DROP_W = 4;
    localparam int          DROP_MAX = (1 << DROP_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              wbValid, wbIsLoad, stValid, trReady;
    logic [PC_W-1:0]   wbPc, stPc;
    logic [4:0]        wbRd;
    logic [31:0]       wbData, wbMemAddr, stAddr, stData, hcIn;
    logic              trValid, overflow;
    logic [1:0]        trKind;
    logic [PC_W-1:0]   trPc;
    logic [4:0]        trRd;
    logic [31:0]       trData, trAddr, trHc;
    logic [DROP_W-1:0] dropCount;

    commit_trace_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .DROP_W(DROP_W)) dut (
        .clk(clk), .rst(rst),
        .wbValid(wbValid), .wbPc(wbPc), .wbRd(wbRd), .wbData(wbData),
        .wbIsLoad(wbIsLoad), .wbMemAddr(wbMemAddr),
        .stValid(stValid), .stPc(stPc), .stAddr(stAddr), .stData(stData),
        .hcIn(hcIn),
        .trValid(trValid), .trReady(trReady), .trKind(trKind), .trPc(trPc), .trRd(trRd),
        .trData(trData), .trAddr(trAddr), .trHc(trHc),
        .overflow(overflow), .dropCount(dropCount)
    );

    typedef struct {
        int unsigned kind;
        logic [PC_W-1:0] pc;
        int unsigned rd;
        logic [31:0] data;
        logic [31:0] addr;
        logic [31:0] hc;
    } rec_t;

    rec_t q[$];
    int   m_drop;
    bit   m_ovf;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_drop();
        m_ovf = 1'b1;
        if (m_drop < DROP_MAX) m_drop++;
    endtask

    // Reference: pop first, then fill remaining room in program order, excess is dropped
    task automatic model_step();
        rec_t r;
        bit   do_pop;
        if (rst) begin
            q.delete();
            m_drop = 0;
            m_ovf  = 1'b0;
            return;
        end
        do_pop = (q.size() > 0) && trReady;
        if (do_pop) void'(q.pop_front());
        if (wbValid) begin
            if (q.size() < DEPTH) begin
                r.kind = wbIsLoad ? 1 : 0;
                r.pc   = wbPc;
                r.rd   = wbRd;
                r.data = wbData;
                r.addr = wbIsLoad ? wbMemAddr : 32'd0;
                r.hc   = hcIn;
                q.push_back(r);
            end else model_drop();
        end
        if (stValid) begin
            if (q.size() < DEPTH) begin
                r.kind = 2;
                r.pc   = stPc;
                r.rd   = 0;
                r.data = stData;
                r.addr = stAddr;
                r.hc   = hcIn;
                q.push_back(r);
            end else model_drop();
        end
    endtask

    task automatic check_outputs();
        logic [31:0] exp_hc;
        check_eq("valid", trValid, q.size() != 0);
        check_eq("overflow", overflow, m_ovf);
        check_eq("dropCount", dropCount, m_drop);
        if (q.size() != 0) begin
`ifdef COMMIT_TRACE_HC_EN
            exp_hc = q[0].hc;
`else
            exp_hc = 32'd0;
`endif
            check_eq("kind", trKind, q[0].kind);
            check_eq("pc", trPc, q[0].pc);
            check_eq("rd", trRd, q[0].rd);
            check_eq("data", trData, q[0].data);
            check_eq("addr", trAddr, q[0].addr);
            check_eq("hc", trHc, exp_hc);
        end else begin
            check_eq("empty_fields", {trKind, trRd, trData, trAddr}, 64'd0);
            check_eq("empty_pc_hc", {trPc, trHc}, 64'd0);
        end
    endtask

    // Advance one cycle: update model with the inputs being applied, then compare
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        hcIn = hcIn + 32'd1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        wbValid = 1'b0; wbIsLoad = 1'b0; stValid = 1'b0;
    endtask

    task automatic set_wb(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] data,
                          input logic ld, input logic [31:0] addr);
        wbValid = 1'b1; wbPc = pc; wbRd = rd; wbData = data; wbIsLoad = ld; wbMemAddr = addr;
    endtask

    task automatic set_st(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] data);
        stValid = 1'b1; stPc = pc; stAddr = addr; stData = data;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        idle_inputs();
        trReady = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) tick();
    endtask

    initial begin
        logic [31:0] cap_hc;
        rst = 1'b1; trReady = 1'b0; hcIn = 32'h1000;
        wbPc = '0; wbRd = '0; wbData = '0; wbMemAddr = '0;
        stPc = '0; stAddr = '0; stData = '0;
        idle_inputs();
        m_drop = 0; m_ovf = 1'b0;

        // Reset state
        do_reset();
        check_eq("rst_valid", trValid, 1'b0);
        check_eq("rst_drop", dropCount, 0);

        // 1: single REG record, one-cycle latency, popped next cycle
        trReady = 1'b1;
        set_wb(32'h10, 5'd5, 32'hDEADBEEF, 1'b0, 32'h0);
        tick();
        idle_inputs();
        check_eq("t1_valid", trValid, 1'b1);
        check_eq("t1_kind", trKind, 0);
        check_eq("t1_rd", trRd, 5);
        check_eq("t1_data", trData, 32'hDEADBEEF);
        tick();
        check_eq("t1_empty", trValid, 1'b0);

        // 2: same-cycle load + store, LOAD ordered first
        set_wb(32'h20, 5'd7, 32'h1234, 1'b1, 32'h100);
        set_st(32'h24, 32'h200, 32'h55);
        tick();
        idle_inputs();
        check_eq("t2_kind0", trKind, 1);
        check_eq("t2_addr0", trAddr, 32'h100);
        tick();
        check_eq("t2_kind1", trKind, 2);
        check_eq("t2_addr1", trAddr, 32'h200);
        check_eq("t2_data1", trData, 32'h55);
        tick();

        // 3: ten pushes into a stalled 8-deep FIFO
        trReady = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_wb(32'h100 + 4 * i, 5'(i + 1), 32'hA000 + i, 1'b0, 32'h0);
            tick();
        end
        idle_inputs();
        check_eq("t3_drop", dropCount, 2);
        check_eq("t3_ovf", overflow, 1'b1);
        trReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq("t3_order", trData, 32'hA000 + i);
            tick();
        end
        check_eq("t3_empty", trValid, 1'b0);
        check_eq("t3_ovf_held", overflow, 1'b1);

        // 4: full FIFO, pop frees a slot for a same-cycle push
        trReady = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_wb(32'h200 + 4 * i, 5'd3, 32'hB000 + i, 1'b0, 32'h0);
            tick();
        end
        trReady = 1'b1;
        set_wb(32'h300, 5'd9, 32'hC0DE, 1'b0, 32'h0);
        tick();
        idle_inputs();
        trReady = 1'b0;
        check_eq("t4_drop", dropCount, 2);
        tick();
        drain();

        // 5: seven queued, WB+STORE -> store dropped
        trReady = 1'b0;
        for (int i = 0; i < 7; i++) begin
            set_wb(32'h400 + 4 * i, 5'd4, 32'hD000 + i, 1'b0, 32'h0);
            tick();
        end
        set_wb(32'h500, 5'd6, 32'hE0, 1'b0, 32'h0);
        set_st(32'h504, 32'h600, 32'hF0);
        tick();
        idle_inputs();
        check_eq("t5_drop", dropCount, 3);
        tick();
        drain();

        // 6: timestamp capture, then reset with five queued
        set_wb(32'h700, 5'd1, 32'h77, 1'b0, 32'h0);
        trReady = 1'b0;
        cap_hc = hcIn;
        tick();
        idle_inputs();
`ifdef COMMIT_TRACE_HC_EN
        check_eq("t6_hc", trHc, cap_hc);
`else
        check_eq("t6_hc", trHc, 32'd0);
`endif
        for (int i = 0; i < 4; i++) begin
            set_wb(32'h710 + 4 * i, 5'd2, 32'h80 + i, 1'b0, 32'h0);
            tick();
        end
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t6_valid", trValid, 1'b0);
        check_eq("t6_drop", dropCount, 0);
        check_eq("t6_ovf", overflow, 1'b0);

        // Saturation of the drop counter
        trReady = 1'b0;
        for (int i = 0; i < 20; i++) begin
            set_wb(32'h800 + 8 * i, 5'd8, i, 1'b0, 32'h0);
            set_st(32'h804 + 8 * i, 32'h900 + i, i);
            tick();
        end
        idle_inputs();
        check_eq("sat_drop", dropCount, DROP_MAX);
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 299) == 0);
            wbValid  = ($urandom_range(0, 99) < 55);
            wbIsLoad = $urandom_range(0, 1);
            wbPc     = $urandom; wbRd = 5'($urandom); wbData = $urandom; wbMemAddr = $urandom;
            stValid  = ($urandom_range(0, 99) < 35);
            stPc     = $urandom; stAddr = $urandom; stData = $urandom;
            trReady  = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 40 : 85));
            tick();
        end
        rst = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
